// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed big-endian byte stream and writes
// 32-bit instruction words into the processor, then drains its pipeline.
module program_loader #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [31:0] instToLoad,
  output logic [31:0] addrToLoad,
  output logic        load,
  output logic        busy,
  output logic        done,
  output logic [15:0] words_loaded
);
  typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, DRAIN, DONE} state_t;
  state_t      state;
  logic [15:0] count;
  logic [15:0] drainCnt;
  logic [1:0]  byteIdx;
  logic [23:0] wordBuf;
  logic        xfer;
  logic [15:0] nextWords;
  assign xfer      = byte_valid && byte_ready;
  assign nextWords = words_loaded + 16'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      byte_ready   <= 1'b0;
      instToLoad   <= 32'd0;
      addrToLoad   <= BASE_ADDR;
      load         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      words_loaded <= 16'd0;
      count        <= 16'd0;
      drainCnt     <= 16'd0;
      byteIdx      <= 2'd0;
      wordBuf      <= 24'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state        <= HDR_HI;
          byte_ready   <= 1'b1;
          busy         <= 1'b1;
          words_loaded <= 16'd0;
          instToLoad   <= 32'd0;
          addrToLoad   <= BASE_ADDR;
          byteIdx      <= 2'd0;
        end
        HDR_HI: if (xfer) begin
          count[15:8] <= byte_in;
          state       <= HDR_LO;
        end
        HDR_LO: if (xfer) begin
          count[7:0] <= byte_in;
          if ({count[15:8], byte_in} == 16'd0) begin
            state      <= DONE;
            byte_ready <= 1'b0;
            done       <= 1'b1;
          end else begin
            state <= DATA;
            load  <= 1'b1;
          end
        end
        DATA: if (xfer) begin
          wordBuf <= {wordBuf[15:0], byte_in};
          byteIdx <= byteIdx + 2'd1;
          // address and word move together so every load cycle rewrites a consistent pair
          if (byteIdx == 2'd3) begin
            instToLoad   <= {wordBuf, byte_in};
            addrToLoad   <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
            words_loaded <= nextWords;
            if (nextWords == count) begin
              state      <= DRAIN;
              byte_ready <= 1'b0;
              drainCnt   <= 16'(DRAIN_CYCLES);
            end
          end
        end
        DRAIN: if (drainCnt <= 16'd1) begin
          state <= DONE;
          load  <= 1'b0;
          done  <= 1'b1;
        end else begin
          drainCnt <= drainCnt - 16'd1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The module SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of the first loaded instruction word.
REQ-002 The module SHALL have parameter DRAIN_CYCLES, default 4: cycles load stays high after the last word, so the pipeline flushes to bubbles.
REQ-003 The module SHALL have port clk  input  1: single clock; all state SHALL change on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 The module SHALL have port start  input  1: begins a load session; sampled only in IDLE.
REQ-006 The module SHALL have port byte_in  input  8: program byte stream.
REQ-007 The module SHALL have port byte_valid  input  1: byte_in holds a valid byte.
REQ-008 The module SHALL have port byte_ready  output  1: loader can accept a byte; a byte transfers on a cycle with byte_valid && byte_ready.
REQ-009 The module SHALL have port instToLoad  output  32: assembled instruction word, driven to the processor.
REQ-010 The module SHALL have port addrToLoad  output  32: memory byte address for instToLoad.
REQ-011 The module SHALL have port load  output  1: processor load/stall strobe; the processor writes instToLoad to addrToLoad on every cycle load is high.
REQ-012 The module SHALL have port busy  output  1: high in every state except IDLE.
REQ-013 The module SHALL have port done  output  1: one-cycle pulse at session end.
REQ-014 The module SHALL have port words_loaded  output  16: count of words written in the current or last session.

Function
REQ-015 The FSM SHALL have states IDLE, HDR_HI, HDR_LO, DATA, DRAIN and DONE.
REQ-016 In IDLE, start=1 SHALL go to HDR_HI and clear words_loaded, instToLoad and the byte index, and SHALL set addrToLoad=BASE_ADDR.
REQ-017 byte_ready SHALL be 1 exactly in HDR_HI, HDR_LO and DATA, and 0 in all other states.
REQ-018 In HDR_HI, an accepted byte SHALL become count[15:8], then the FSM SHALL go to HDR_LO.
REQ-019 In HDR_LO, an accepted byte SHALL become count[7:0]; the next state SHALL be DONE if the full count is 0, else DATA.
REQ-020 In DATA, bytes SHALL be assembled MSB-first (big-endian) with a 2-bit byte index 0..3.
REQ-021 When a word completes, on the edge that accepts byte index 3, the module SHALL set instToLoad=word and addrToLoad=BASE_ADDR+4*words_loaded (modulo 2^32), and SHALL increment words_loaded.
REQ-022 instToLoad and addrToLoad SHALL change only together, on word completion; between completions they SHALL hold, so repeated writes only rewrite the previous word.
REQ-023 When words_loaded reaches count on word completion, the FSM SHALL go to DRAIN with a drain counter of DRAIN_CYCLES.
REQ-024 load SHALL be 1 in DATA and DRAIN, and 0 otherwise; asserting load in DATA before the first word writes 32'h0 to BASE_ADDR, which the first word later overwrites.
REQ-025 DRAIN SHALL last exactly DRAIN_CYCLES cycles, then the FSM SHALL go to DONE.
REQ-026 DONE SHALL last one cycle with done=1, then the FSM SHALL return to IDLE.
REQ-027 words_loaded SHALL hold its value in IDLE until the next start.
REQ-028 start outside IDLE SHALL be ignored.
REQ-029 byte_valid=0 SHALL stall the FSM in its current state with all registers held; load SHALL stay high during a DATA stall.
REQ-030 count=0xFFFF SHALL load 65535 words with no overflow of words_loaded.

Reset
REQ-031 rst_n=0 SHALL immediately (asynchronously) force state=IDLE, load=0, busy=0, done=0, byte_ready=0, instToLoad=0, addrToLoad=BASE_ADDR, words_loaded=0 and byte index=0.
REQ-032 Reset mid-session SHALL abandon the session with no done pulse; the next session SHALL require a new start after rst_n=1.

Verification
REQ-033 The bench SHALL cover a two-word load: start, bytes 00 02 20 08 00 05 AC 01 00 04 -> writes 0x20080005@0x0 then 0xAC010004@0x4, load high through 4 DRAIN cycles, done pulse, words_loaded=2.
REQ-034 The bench SHALL cover an empty program: start, bytes 00 00 -> done one cycle after the HDR_LO transfer, load never 1, words_loaded=0.
REQ-035 The bench SHALL cover stalls: byte_valid toggled randomly in DATA -> identical words and addresses as with the unstalled stream, load continuously 1.
REQ-036 The bench SHALL cover reset mid-word: rst_n low after 2 DATA bytes -> load=0 in the same cycle, state IDLE, words_loaded=0, no done pulse.
REQ-037 The bench SHALL cover base address and ignored start: BASE_ADDR=0x100, count=3, start pulsed during DATA -> addresses 0x100, 0x104 and 0x108, and the session is not restarted.
REQ-038 The bench SHALL cover a drain parameter change: DRAIN_CYCLES=2 -> load falls exactly 2 cycles after the last word completes, and done follows on the next cycle.
